clock_tick_controller: RTL and testbench
========================================

Name: clock_tick_controller

Overview:
- Sequencer for the digital clock's flip-flop counter datapath. It generates the single-cycle Tick enables that advance the seconds, minutes and hours counters.
- Divides Clock down to a one-second timebase and cascades carries using max-value flags returned by the datapath.
- Runs a button-driven set-mode FSM so the user can adjust hours and minutes.
- All Tick outputs are synchronous to the rising edge of Clock, for direct use as flop Tick enables.

Parameters:
- CLK_DIV, 50000000, Clock cycles per second; legal range 2 to 2^DIV_WIDTH.
- DIV_WIDTH, 26, width of the prescaler counter.

Ports:
- Clock  in  1  system clock; all state updates on its rising edge.
- Reset  in  1  asynchronous, active-high reset.
- Mode_Btn  in  1  debounced, Clock-synchronous mode button level.
- Inc_Btn  in  1  debounced, Clock-synchronous increment button level.
- Sec_Max  in  1  seconds counter currently holds 59.
- Min_Max  in  1  minutes counter currently holds 59.
- Sec_Tick  out  1  one-cycle enable: advance the seconds counter.
- Min_Tick  out  1  one-cycle enable: advance the minutes counter.
- Hour_Tick  out  1  one-cycle enable: advance the hours counter.
- Sec_Clear  out  1  one-cycle pulse: clear the seconds counter to 0.
- Mode  out  2  current state: 00 RUN, 01 SET_HR, 10 SET_MIN.

Behaviour:
- Reset (asynchronous, takes effect immediately, including mid-operation):
  - state RUN, prescaler 0;
  - button history registers 1, so a button held through reset is not a press;
  - Sec_Tick, Min_Tick, Hour_Tick and Sec_Clear are 0; Mode is 00.
- Press detection: press = Btn & ~Btn_prev, with Btn_prev registered every cycle. Holding a button produces exactly one press.
- Prescaler:
  - In RUN it counts 0..CLK_DIV-1 and wraps to 0.
  - one_sec is asserted in the cycle where count == CLK_DIV-1.
  - In SET_HR and SET_MIN it is held at 0.
- All outputs are registered. Each Tick and Sec_Clear output is high for exactly one cycle, in the cycle after its qualifying condition.
- RUN:
  - Sec_Tick <= one_sec.
  - Min_Tick <= one_sec & Sec_Max.
  - Hour_Tick <= one_sec & Sec_Max & Min_Max.
  - Sec_Max and Min_Max are sampled in the same cycle as one_sec.
  - Inc_Btn presses are ignored.
- SET_HR: Hour_Tick <= Inc press. Sec_Tick and Min_Tick stay 0.
- SET_MIN: Min_Tick <= Inc press, with no carry into hours. Sec_Tick and Hour_Tick stay 0.
- State transitions, all on a Mode press:
  - RUN -> SET_HR; the prescaler is cleared to 0 on the transition.
  - SET_HR -> SET_MIN.
  - SET_MIN -> RUN; Sec_Clear is pulsed on the transition, and the prescaler starts from 0.
- After a return to RUN, the first Sec_Tick appears CLK_DIV cycles after the Sec_Clear cycle.
- Simultaneous Mode and Inc press: Mode wins; no Tick is generated in that cycle.
- In RUN, a Mode press in the same cycle as one_sec: the transition wins and no Tick is generated.
- Mode output: a registered copy of the state, updated in the same edge as the transition.
- Illegal state encoding 11: returns to RUN on the next clock, with no Tick outputs.
- Hours wrap (23 -> 0) is owned by the datapath and is not detected here.

Test Plan (CLK_DIV=4):
- Reset asserted while Mode_Btn is held high, then released -> Mode=00 and no state change until the button is released and pressed again. All outputs stay 0 throughout.
- RUN, Sec_Max=0, 12 cycles after reset -> Sec_Tick pulses on cycles 4, 8 and 12 after reset release, each exactly 1 cycle wide. Min_Tick and Hour_Tick stay 0.
- RUN, Sec_Max=1, Min_Max=1 at the fourth cycle -> Sec_Tick, Min_Tick and Hour_Tick all high together for one cycle.
- Mode press, then Inc held high for 5 cycles -> Mode=01 and one Hour_Tick only. Second Mode press then two Inc presses -> Mode=10 and two Min_Tick pulses.
- From SET_MIN, Mode press -> Mode=00 and a Sec_Clear pulse. The next Sec_Tick arrives exactly 4 cycles after Sec_Clear.
- Mode and Inc rising together in SET_HR -> Mode=10 with no Hour_Tick. Reset asserted mid-SET_MIN -> Mode=00 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/clock_tick_controller.sv
// Tick sequencer for the digital clock datapath.
// Divides Clock to a one-second timebase, cascades seconds/minutes/hours
// carries from the datapath max flags, and runs the button set-mode FSM.
module clock_tick_controller #(
  parameter int CLK_DIV   = 50000000,
  parameter int DIV_WIDTH = 26
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Mode_Btn,
  input  logic       Inc_Btn,
  input  logic       Sec_Max,
  input  logic       Min_Max,
  output logic       Sec_Tick,
  output logic       Min_Tick,
  output logic       Hour_Tick,
  output logic       Sec_Clear,
  output logic [1:0] Mode
);

  typedef enum logic [1:0] {
    ST_RUN     = 2'b00,
    ST_SET_HR  = 2'b01,
    ST_SET_MIN = 2'b10
  } state_t;

  // Last prescaler value before wrap; the one-second strobe fires here.
  localparam logic [DIV_WIDTH-1:0] LP_LAST = DIV_WIDTH'(CLK_DIV - 1);

  state_t               r_state;
  logic [DIV_WIDTH-1:0] r_count;
  logic                 r_mode_prev;
  logic                 r_inc_prev;
  logic                 r_sec_tick;
  logic                 r_min_tick;
  logic                 r_hour_tick;
  logic                 r_sec_clear;
  logic [1:0]           r_mode;

  logic w_mode_press;
  logic w_inc_press;
  logic w_one_sec;

  // Rising-edge press detection against last cycle's button level;
  // one_sec is only meaningful while the prescaler runs in RUN.
  always_comb begin
    w_mode_press = Mode_Btn & ~r_mode_prev;
    w_inc_press  = Inc_Btn & ~r_inc_prev;
    w_one_sec    = (r_state == ST_RUN) && (r_count == LP_LAST);
  end

  // FSM, prescaler, button history and all registered outputs.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state     <= ST_RUN;
      r_count     <= '0;
      // History starts high so a button held through reset is not a press.
      r_mode_prev <= 1'b1;
      r_inc_prev  <= 1'b1;
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_sec_clear <= 1'b0;
      r_mode      <= ST_RUN;
    end else begin
      r_mode_prev <= Mode_Btn;
      r_inc_prev  <= Inc_Btn;
      // Pulses default low so each is exactly one cycle wide.
      r_sec_tick  <= 1'b0;
      r_min_tick  <= 1'b0;
      r_hour_tick <= 1'b0;
      r_sec_clear <= 1'b0;

      case (r_state)
        ST_RUN: begin
          if (w_mode_press) begin
            // Entering set mode beats a coincident one-second strobe.
            r_state <= ST_SET_HR;
            r_mode  <= ST_SET_HR;
            r_count <= '0;
          end else begin
            r_count     <= w_one_sec ? '0 : r_count + DIV_WIDTH'(1);
            r_sec_tick  <= w_one_sec;
            r_min_tick  <= w_one_sec & Sec_Max;
            r_hour_tick <= w_one_sec & Sec_Max & Min_Max;
          end
        end

        ST_SET_HR: begin
          r_count <= '0;
          if (w_mode_press) begin
            r_state <= ST_SET_MIN;
            r_mode  <= ST_SET_MIN;
          end else begin
            r_hour_tick <= w_inc_press;
          end
        end

        ST_SET_MIN: begin
          r_count <= '0;
          if (w_mode_press) begin
            // Seconds restart from zero; the prescaler is already at 0,
            // so the first Sec_Tick lands CLK_DIV cycles after this pulse.
            r_state     <= ST_RUN;
            r_mode      <= ST_RUN;
            r_sec_clear <= 1'b1;
          end else begin
            // Minute adjust never carries into hours.
            r_min_tick <= w_inc_press;
          end
        end

        default: begin
          // Unused encoding: recover to RUN quietly.
          r_state <= ST_RUN;
          r_mode  <= ST_RUN;
          r_count <= '0;
        end
      endcase
    end
  end

  assign Sec_Tick  = r_sec_tick;
  assign Min_Tick  = r_min_tick;
  assign Hour_Tick = r_hour_tick;
  assign Sec_Clear = r_sec_clear;
  assign Mode      = r_mode;

endmodule

// File: tb/tb_clock_tick_controller.sv
// Scoreboard bench for clock_tick_controller with CLK_DIV=4.
// Expected output events {Sec,Min,Hour,Clear,Mode} are queued with the cycle
// (posedges since reset release) in which they must appear; a monitor pops
// and compares whenever a pulse is high or Mode changes.
module tb_clock_tick_controller;

  logic       Clock;
  logic       Reset;
  logic       Mode_Btn;
  logic       Inc_Btn;
  logic       Sec_Max;
  logic       Min_Max;
  logic       Sec_Tick;
  logic       Min_Tick;
  logic       Hour_Tick;
  logic       Sec_Clear;
  logic [1:0] Mode;

  typedef struct {
    int         cyc;
    logic [5:0] val;
  } ev_t;

  ev_t  exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc;
  logic [1:0] mon_mode_prev = 2'b00;

  clock_tick_controller #(.CLK_DIV(4), .DIV_WIDTH(3)) dut (
    .Clock(Clock), .Reset(Reset), .Mode_Btn(Mode_Btn), .Inc_Btn(Inc_Btn),
    .Sec_Max(Sec_Max), .Min_Max(Min_Max), .Sec_Tick(Sec_Tick),
    .Min_Tick(Min_Tick), .Hour_Tick(Hour_Tick), .Sec_Clear(Sec_Clear),
    .Mode(Mode)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Posedges since the last reset release.
  always @(posedge Clock or posedge Reset) begin
    if (Reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  task automatic check(input string name, input int got, input int req);
    checks++;
    if (got != req) begin
      failures++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end else begin
      $display("check %s value=%0d ok", name, got);
    end
  endtask

  task automatic push(input int c, input logic [5:0] v);
    ev_t e;
    e.cyc = c;
    e.val = v;
    exp_q.push_back(e);
  endtask

  // Wait until the negedge at which cyc == n (n must be in the future).
  task automatic at_cyc(input int n);
    do @(negedge Clock); while (cyc < n);
  endtask

  task automatic monitor();
    logic [5:0] ev;
    ev_t        e;
    forever begin
      @(negedge Clock);
      if (Reset) begin
        mon_mode_prev = Mode;
      end else begin
        while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
          e = exp_q.pop_front();
          checks++;
          failures++;
          $display("FAIL missing_event cyc=%0d got=none required=%b", e.cyc, e.val);
        end
        ev = {Sec_Tick, Min_Tick, Hour_Tick, Sec_Clear, Mode};
        if (ev[5:2] != 4'b0000 || Mode != mon_mode_prev) begin
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_event cyc=%0d got=%b required=none", cyc, ev);
          end else begin
            e = exp_q.pop_front();
            if (e.cyc != cyc || e.val != ev) begin
              failures++;
              $display("FAIL event cyc=%0d got=%b required cyc=%0d val=%b",
                       cyc, ev, e.cyc, e.val);
            end else begin
              $display("event cyc=%0d val=%b ok", cyc, ev);
            end
          end
        end
        mon_mode_prev = Mode;
      end
    end
  endtask

  initial begin
    Reset = 1'b1; Mode_Btn = 1'b1; Inc_Btn = 1'b0; Sec_Max = 1'b0; Min_Max = 1'b0;
    fork monitor(); join_none

    // Reset with Mode held: all outputs quiet.
    for (int i = 0; i < 3; i++) begin
      @(negedge Clock);
      check("reset_outputs", {Sec_Tick, Min_Tick, Hour_Tick, Sec_Clear, Mode}, 0);
    end

    // Hand-computed event schedule (bits: Sec Min Hour Clear Mode[1:0]).
    push(4,  6'b100000);  // free-running seconds
    push(8,  6'b100000);
    push(12, 6'b100000);
    push(16, 6'b111000);  // full carry into minutes and hours
    push(18, 6'b000001);  // RUN -> SET_HR
    push(20, 6'b001001);  // single hour tick for held Inc
    push(26, 6'b000010);  // SET_HR -> SET_MIN
    push(28, 6'b010010);
    push(30, 6'b010010);
    push(32, 6'b000100);  // SET_MIN -> RUN with Sec_Clear
    push(36, 6'b100000);  // 4 cycles after Sec_Clear
    push(40, 6'b000001);  // Mode press wins over one_sec
    push(42, 6'b000010);  // Mode+Inc together: no hour tick

    @(negedge Clock);
    Reset = 1'b0;                               // cyc == 0
    at_cyc(13); Mode_Btn = 1'b0;                // held button never counted
    at_cyc(14); Sec_Max = 1'b1; Min_Max = 1'b1;
    at_cyc(16); Sec_Max = 1'b0; Min_Max = 1'b0;
    at_cyc(17); Mode_Btn = 1'b1;
    at_cyc(18); Mode_Btn = 1'b0;
    at_cyc(19); Inc_Btn = 1'b1;
    at_cyc(24); Inc_Btn = 1'b0;
    at_cyc(25); Mode_Btn = 1'b1;
    at_cyc(26); Mode_Btn = 1'b0;
    at_cyc(27); Inc_Btn = 1'b1;
    at_cyc(28); Inc_Btn = 1'b0;
    at_cyc(29); Inc_Btn = 1'b1;
    at_cyc(30); Inc_Btn = 1'b0;
    at_cyc(31); Mode_Btn = 1'b1;
    at_cyc(32); Mode_Btn = 1'b0;
    at_cyc(39); Mode_Btn = 1'b1;
    at_cyc(40); Mode_Btn = 1'b0;
    at_cyc(41); Mode_Btn = 1'b1; Inc_Btn = 1'b1;
    at_cyc(42); Mode_Btn = 1'b0; Inc_Btn = 1'b0;
    at_cyc(43);
    check("phase1_drained", exp_q.size(), 0);

    // Asynchronous reset in SET_MIN, between clock edges.
    #2 Reset = 1'b1;
    #1;
    check("async_reset_mode", Mode, 0);
    check("async_reset_pulses", {Sec_Tick, Min_Tick, Hour_Tick, Sec_Clear}, 0);
    @(negedge Clock);
    Reset = 1'b0;                               // cyc == 0
    push(4, 6'b100000);
    push(8, 6'b100000);
    at_cyc(10);
    check("final_drained", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
